// File: rtl/mic_mux_pkg.sv
// Shared definitions for the 2-mic time-multiplexed nibble link (transmitter and demultiplexer).
// Stream word layout: [NIB_MSB:NIB_LSB] = nibble (sample MSB-first), [TAG_BIT] = channel tag.
package mic_mux_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned WPC       = SAMPLE_W / NIB_W;
  localparam int unsigned FRAME_LEN = NUM_CH * WPC;

  localparam int unsigned TAG_BIT = 0;
  localparam int unsigned NIB_LSB = 1;
  localparam int unsigned NIB_MSB = NIB_W;

  typedef logic [NIB_W:0]      mux_word_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } demux_state_t;

  // Pack a nibble and its channel tag into one stream word.
  function automatic mux_word_t mux_word(input logic [NIB_W-1:0] nib, input logic tag);
    return {nib, tag};
  endfunction

endpackage

// File: rtl/demultiplexer.sv
// Receive end of the 2-mic nibble stream: finds frame alignment from the tag pattern
// 0,0,0,0,1,1,1,1, rebuilds both 16-bit samples and presents them as a parallel pair.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_data    stream word, [NIB_W:1] nibble MSB-first, [0] channel tag
//   out_data   [0] tag-0 sample, [1] tag-1 sample; held until the next out_valid
//   out_valid  one-cycle pulse for a new out_data pair
//   locked     high while the FSM is in LOCKED
//   sync_err   one-cycle pulse on a tag mismatch in ACQUIRE/LOCKED
//   err_count  saturating count of sync_err pulses
module demultiplexer
  import mic_mux_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIB_W:0]       in_data,
  output logic [SAMPLE_W-1:0]  out_data [NUM_CH],
  output logic                 out_valid,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned POS_W = $clog2(FRAME_LEN);
  localparam int unsigned GF_W  = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned SH_W  = SAMPLE_W - NIB_W;

  demux_state_t         state, state_nxt;
  logic [POS_W-1:0]     pos, pos_nxt;
  logic [GF_W-1:0]      good_frames, good_frames_nxt;
  logic                 prev_tag;
  sample_t              shreg [NUM_CH];
  sample_t              shreg_nxt [NUM_CH];
  sample_t              out_data_nxt [NUM_CH];
  logic                 out_valid_nxt, sync_err_nxt;
  logic [ERR_CNT_W-1:0] err_count_nxt;

  logic                 tag, sof, exp_tag, last_pos;
  logic [NIB_W-1:0]     nib;
  sample_t              shift0, shift1;

  assign tag      = in_data[TAG_BIT];
  assign nib      = in_data[NIB_MSB:NIB_LSB];
  assign sof      = prev_tag & ~tag;
  assign exp_tag  = (pos >= POS_W'(WPC));
  assign last_pos = (pos == POS_W'(FRAME_LEN - 1));
  assign shift0   = {shreg[0][SH_W-1:0], nib};
  assign shift1   = {shreg[1][SH_W-1:0], nib};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt       = state;
    pos_nxt         = pos;
    good_frames_nxt = good_frames;
    shreg_nxt       = shreg;
    out_data_nxt    = out_data;
    out_valid_nxt   = 1'b0;
    sync_err_nxt    = 1'b0;
    err_count_nxt   = err_count;

    case (state)
      HUNT: begin
        if (sof) begin
          shreg_nxt[0]    = shift0;
          pos_nxt         = POS_W'(1);
          good_frames_nxt = '0;
          state_nxt       = ACQUIRE;
        end
      end

      ACQUIRE, LOCKED: begin
        if (tag != exp_tag) begin
          // Checked before any emit, so a bad last word drops the whole frame.
          sync_err_nxt = 1'b1;
          if (err_count != '1) err_count_nxt = err_count + ERR_CNT_W'(1);
          good_frames_nxt = '0;
          if (sof) begin
            // The offending word starts a new frame; restart acquisition on it.
            shreg_nxt[0] = shift0;
            pos_nxt      = POS_W'(1);
            state_nxt    = ACQUIRE;
          end else begin
            pos_nxt   = '0;
            state_nxt = HUNT;
          end
        end else begin
          if (tag) shreg_nxt[1] = shift1;
          else     shreg_nxt[0] = shift0;

          if (last_pos) begin
            pos_nxt = '0;
            if (state == LOCKED) begin
              out_data_nxt[0] = shreg[0];
              out_data_nxt[1] = shift1;
              out_valid_nxt   = 1'b1;
            end else begin
              good_frames_nxt = good_frames + GF_W'(1);
              // The frame that completes the lock count is emitted too.
              if (good_frames == GF_W'(LOCK_FRAMES - 1)) begin
                state_nxt       = LOCKED;
                out_data_nxt[0] = shreg[0];
                out_data_nxt[1] = shift1;
                out_valid_nxt   = 1'b1;
              end
            end
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end
      end

      default: begin
        state_nxt = HUNT;
        pos_nxt   = '0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos         <= '0;
      good_frames <= '0;
      prev_tag    <= 1'b0;
      shreg       <= '{default: '0};
      out_data    <= '{default: '0};
      out_valid   <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      pos         <= pos_nxt;
      good_frames <= good_frames_nxt;
      prev_tag    <= tag;
      shreg       <= shreg_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      locked      <= (state_nxt == LOCKED);
      sync_err    <= sync_err_nxt;
      err_count   <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_demultiplexer.sv
// Self-checking bench for demultiplexer: transmitter-style frame generator, expected
// sample pairs queued when a frame is driven and compared when out_valid appears.
module tb_demultiplexer;
  import mic_mux_pkg::*;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int          ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic [NIB_W:0]       in_data;
  logic [SAMPLE_W-1:0]  out_data [NUM_CH];
  logic                 out_valid;
  logic                 locked;
  logic                 sync_err;
  logic [ERR_CNT_W-1:0] err_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_err     = 0;
  int cyc         = 0;
  int last_valid  = -1000;

  logic [2*SAMPLE_W-1:0] exp_q [$];

  demultiplexer #(.LOCK_FRAMES(2), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word p of a frame carrying samples a (tag 0) and b (tag 1), MSB nibble first.
  function automatic mux_word_t frame_word(input sample_t a, input sample_t b, input int p);
    sample_t          s;
    int               k;
    logic [NIB_W-1:0] nib;
    s   = (p < int'(WPC)) ? a : b;
    k   = p % int'(WPC);
    nib = s[int'(SAMPLE_W) - 1 - k*int'(NIB_W) -: NIB_W];
    return mux_word(nib, (p >= int'(WPC)));
  endfunction

  // Drive one word, let the DUT sample it, then score any pair it produced.
  task automatic send_word(input mux_word_t w);
    logic [2*SAMPLE_W-1:0] got, exp;
    @(negedge clk);
    in_data = w;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      got = {out_data[0], out_data[1]};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got %h/%h, no pair pending", out_data[0], out_data[1]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL pair: got %h/%h, expected %h/%h", got[2*SAMPLE_W-1 -: SAMPLE_W],
                   got[SAMPLE_W-1:0], exp[2*SAMPLE_W-1 -: SAMPLE_W], exp[SAMPLE_W-1:0]);
        end
      end
      vectors++;
      if (locked !== 1'b1) begin
        miscompares++;
        $display("FAIL valid_without_lock: locked=%b, expected 1", locked);
      end
      vectors++;
      if (cyc - last_valid < int'(FRAME_LEN)) begin
        miscompares++;
        $display("FAIL valid_gap: %0d cycles, expected >= %0d", cyc - last_valid, FRAME_LEN);
      end
      last_valid = cyc;
    end
  endtask

  task automatic send_frame(input sample_t a, input sample_t b, input bit emit);
    if (emit) exp_q.push_back({a, b});
    for (int p = 0; p < int'(FRAME_LEN); p++) send_word(frame_word(a, b, p));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send_word('0);
    send_word('0);
    vectors++;
    if ({out_valid, locked, sync_err} !== 3'b000 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset_flags: valid=%b locked=%b sync_err=%b err_count=%0d, expected all 0",
               out_valid, locked, sync_err, err_count);
    end
    vectors++;
    if (out_data[0] !== '0 || out_data[1] !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h, expected 0000/0000", out_data[0], out_data[1]);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_acquire();
    send_frame(16'h1234, 16'hABCD, 1'b0);   // no SOF yet: prev tag was 0
    send_frame(16'h1234, 16'hABCD, 1'b0);   // first clean frame
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_early: locked=%b, expected 0", locked);
    end
    send_frame(16'h1234, 16'hABCD, 1'b1);   // second clean frame promotes and emits
    vectors++;
    if (locked !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_rise: locked=%b valid=%b, expected 1/1", locked, out_valid);
    end
    send_frame(16'h1234, 16'hABCD, 1'b1);
    send_frame(16'h1234, 16'hABCD, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_frame(16'hFFFF, 16'h0000, 1'b1);
    exp_q.push_back({16'h0001, 16'h8000});
    for (int p = 0; p < int'(FRAME_LEN); p++) begin
      send_word(frame_word(16'h0001, 16'h8000, p));
      if (p == 3) begin
        vectors++;
        if (out_valid !== 1'b0 || out_data[0] !== 16'hFFFF || out_data[1] !== 16'h0000) begin
          miscompares++;
          $display("FAIL hold: valid=%b data=%h/%h, expected 0 FFFF/0000",
                   out_valid, out_data[0], out_data[1]);
        end
      end
    end
    send_frame(16'h5A5A, 16'hC3C3, 1'b1);
  endtask

  task automatic test_tag_error();
    mux_word_t w;
    for (int p = 0; p < int'(FRAME_LEN); p++) begin
      w = frame_word(16'h1111, 16'h2222, p);
      if (p == 4) w[TAG_BIT] = ~w[TAG_BIT];   // first ch1 word: flipped tag is not an SOF
      send_word(w);
      if (p == 4) begin
        exp_err++;
        vectors++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || err_count !== ERR_CNT_W'(exp_err)) begin
          miscompares++;
          $display("FAIL tag_err: sync_err=%b locked=%b err_count=%0d, expected 1/0/%0d",
                   sync_err, locked, err_count, exp_err);
        end
      end
      if (p == 5) begin
        vectors++;
        if (sync_err !== 1'b0) begin
          miscompares++;
          $display("FAIL tag_err_pulse: sync_err=%b, expected 0", sync_err);
        end
      end
    end
    send_frame(16'h3333, 16'h4444, 1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_early: locked=%b, expected 0", locked);
    end
    send_frame(16'h5555, 16'h6666, 1'b1);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL relock: locked=%b, expected 1", locked);
    end
  endtask

  task automatic test_slip();
    for (int p = 0; p < int'(FRAME_LEN); p++)
      if (p != 5) send_word(frame_word(16'h7777, 16'h8888, p));
    // Next frame's first word lands on expected pos 7 and is an SOF: restart there.
    for (int p = 0; p < int'(FRAME_LEN); p++) begin
      send_word(frame_word(16'h9999, 16'hAAAA, p));
      if (p == 0) begin
        exp_err++;
        vectors++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || err_count !== ERR_CNT_W'(exp_err)) begin
          miscompares++;
          $display("FAIL slip_err: sync_err=%b locked=%b err_count=%0d, expected 1/0/%0d",
                   sync_err, locked, err_count, exp_err);
        end
      end
    end
    send_frame(16'hBEEF, 16'hCAFE, 1'b1);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL slip_relock: locked=%b, expected 1", locked);
    end
  endtask

  task automatic test_err_saturation();
    send_word(mux_word(4'h0, 1'b1));   // locked, pos 0 expects tag 0
    exp_err++;
    for (int i = 0; i < 300; i++) begin
      send_word(mux_word(4'h0, 1'b0)); // SOF from HUNT
      send_word(mux_word(4'h0, 1'b1)); // ACQUIRE pos 1 mismatch
      if (exp_err < ERR_MAX) exp_err++;
      vectors++;
      if (sync_err !== 1'b1 || err_count !== ERR_CNT_W'(exp_err)) begin
        miscompares++;
        $display("FAIL err_count: iter %0d sync_err=%b err_count=%0d, expected 1/%0d",
                 i, sync_err, err_count, exp_err);
      end
    end
    vectors++;
    if (err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL err_sat: err_count=%0d, expected 255", err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    send_frame(16'h1357, 16'h2468, 1'b1);
    for (int p = 0; p < int'(FRAME_LEN); p++) begin
      rst = (p == 3);
      send_word(frame_word(16'hDEAD, 16'hD00D, p));
      rst = 1'b0;
      if (p == 3) begin
        exp_err = 0;
        vectors++;
        if ({out_valid, locked, sync_err} !== 3'b000 || err_count !== '0 ||
            out_data[0] !== '0 || out_data[1] !== '0) begin
          miscompares++;
          $display("FAIL mid_reset: valid=%b locked=%b sync_err=%b cnt=%0d data=%h/%h, expected 0",
                   out_valid, locked, sync_err, err_count, out_data[0], out_data[1]);
        end
      end
    end
    send_frame(16'h4321, 16'h8765, 1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_relock_early: locked=%b, expected 0", locked);
    end
    send_frame(16'h0123, 16'h4567, 1'b1);
    vectors++;
    if (locked !== 1'b1 || err_count !== ERR_CNT_W'(exp_err)) begin
      miscompares++;
      $display("FAIL reset_relock: locked=%b err_count=%0d, expected 1/%0d",
               locked, err_count, exp_err);
    end
  endtask

  initial begin
    rst     = 1'b1;
    in_data = '0;
    test_reset();
    test_lock_acquire();
    test_back_to_back();
    test_tag_error();
    test_slip();
    test_err_saturation();
    test_reset_mid_frame();
    send_word('0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pairs: %0d pairs never delivered, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
